// File: rtl/sram_access_ctrl.sv
// Request/ack front end sequencing single-byte accesses onto an async SRAM bus
// with programmable setup/strobe/hold phases; DQ driven only while nWE is low.
module sram_access_ctrl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [20:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [20:0] SRAM_A,
  inout  wire  [7:0]  SRAM_DQ,
  output logic        SRAM_nCE,
  output logic        SRAM_nOE,
  output logic        SRAM_nWE
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [20:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nce_q, nce_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic        ack_q, ack_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 21'd0;
      we_q    <= 1'b0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      nce_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nce_q   <= nce_d;
      noe_q   <= noe_d;
      nwe_q   <= nwe_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nce_d   = nce_q;
    noe_d   = noe_q;
    nwe_d   = nwe_q;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          cnt_d   = 4'(SETUP_CYC - 1);
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          nce_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'(ACCESS_CYC - 1);
          noe_d   = we_q;
          nwe_d   = ~we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        // Read data is sampled on the same edge that releases nOE.
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = 4'(HOLD_CYC - 1);
          noe_d   = 1'b1;
          nwe_d   = 1'b1;
          if (!we_q) rdata_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          nce_d   = 1'b1;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The downstream wrapper owns DQ whenever nWE is high.
  assign SRAM_DQ  = nwe_q ? 8'hzz : wdata_q;
  assign SRAM_A   = addr_q;
  assign SRAM_nCE = nce_q;
  assign SRAM_nOE = noe_q;
  assign SRAM_nWE = nwe_q;
  assign busy     = (state_q != ST_IDLE);
  assign ack      = ack_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: SRAM bus model, transaction-level memory reference,
// directed and randomized accesses on a default instance and a slow-timing instance.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Default-timing instance
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [20:0] addr0 = '0;
  logic [7:0]  wdata0 = '0;
  logic        busy0, ack0, nce0, noe0, nwe0;
  logic [7:0]  rdata0;
  logic [20:0] a0;
  wire  [7:0]  dq0;

  sram_access_ctrl u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .SRAM_A(a0), .SRAM_DQ(dq0),
    .SRAM_nCE(nce0), .SRAM_nOE(noe0), .SRAM_nWE(nwe0)
  );

  // Slow-timing instance (setup 2, access 4, hold 1)
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [20:0] addr1 = '0;
  logic [7:0]  wdata1 = '0;
  logic        busy1, ack1, nce1, noe1, nwe1;
  logic [7:0]  rdata1;
  logic [20:0] a1;
  wire  [7:0]  dq1;

  sram_access_ctrl #(.SETUP_CYC(2), .ACCESS_CYC(4), .HOLD_CYC(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .ack(ack1), .rdata(rdata1), .SRAM_A(a1), .SRAM_DQ(dq1),
    .SRAM_nCE(nce1), .SRAM_nOE(noe1), .SRAM_nWE(nwe1)
  );

  // SRAM bus model: initial content is a fixed function of the address
  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0] bmem [logic [20:0]];
  logic [7:0] bus_drv0 = 8'h00;
  always @(a0 or noe0) bus_drv0 = bmem.exists(a0) ? bmem[a0] : dflt(a0);
  assign dq0 = (!nce0 && !noe0) ? bus_drv0 : 8'hzz;
  always @(negedge clk) if (!nwe0 && !nce0) bmem[a0] = dq0;

  assign dq1 = (!nce1 && !noe1) ? (a1[7:0] ^ 8'h96) : 8'hzz;

  // Transaction-level reference: what each completed read must return
  logic [7:0] ref_mem [logic [20:0]];
  logic [7:0] last_rd = 8'h00;

  function automatic logic [7:0] exp_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one access on the default instance starting from an idle/ack cycle and
  // check every cycle through the ack cycle. Phases: setup 1, strobe 2, hold 1.
  task automatic txn0(input bit w, input logic [20:0] a, input logic [7:0] d,
                      input bit hold_req, input bit pulse);
    logic [7:0] er;
    bit strobe;
    er = exp_rd(a);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    tick();
    if (!hold_req) req0 = 1'b0;
    we0 = 1'($urandom); addr0 = 21'($urandom); wdata0 = 8'($urandom);
    for (int k = 0; k <= 4; k++) begin
      strobe = (k >= 1 && k <= 2);
      if (pulse && !hold_req) req0 = (k == 2);
      chk("nCE", nce0, (k < 4) ? 1'b0 : 1'b1);
      chk("nWE", nwe0, (strobe && w) ? 1'b0 : 1'b1);
      chk("nOE", noe0, (strobe && !w) ? 1'b0 : 1'b1);
      chk("busy", busy0, k < 4);
      chk("ack", ack0, k == 4);
      chk("SRAM_A", a0, a);
      if (strobe && w)      chk("dq_write", dq0, d);
      else if (strobe)      chk("dq_read", dq0, er);
      else                  chk("dq_z", dq0, 8'hzz);
      if (k == 4) begin
        if (!w) last_rd = er;
        chk("rdata", rdata0, last_rd);
      end
      if (k < 4) tick();
    end
    if (w) ref_mem[a] = d;
  endtask

  task automatic chk_reset_state;
    chk("rst_nCE", nce0, 1'b1);
    chk("rst_nOE", noe0, 1'b1);
    chk("rst_nWE", nwe0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ack", ack0, 1'b0);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_A", a0, 21'h0);
    chk("rst_dq", dq0, 8'hzz);
  endtask

  initial begin
    bmem[21'h00123]    = 8'hC3;
    ref_mem[21'h00123] = 8'hC3;

    // Reset from power-up, then again while idle
    repeat (3) tick();
    chk_reset_state();
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_nCE1", nce1, 1'b1);
    @(negedge clk) reset = 1'b0;
    repeat (2) tick();
    chk_reset_state();
    reset = 1'b1;
    #1;
    chk_reset_state();
    @(negedge clk) reset = 1'b0;
    tick();

    // Directed write, read, rdata held through a write
    txn0(1'b1, 21'h1A5A5, 8'h3C, 1'b0, 1'b0);
    tick();
    txn0(1'b0, 21'h00123, 8'h00, 1'b0, 1'b0);
    tick();
    txn0(1'b1, 21'h00200, 8'h11, 1'b0, 1'b0);
    tick();

    // Back-to-back with req held high, then a stray pulse while busy
    txn0(1'b1, 21'h00010, 8'h55, 1'b1, 1'b0);
    txn0(1'b0, 21'h00010, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_busy", busy0, 1'b0);
      chk("idle_nCE", nce0, 1'b1);
      chk("idle_ack", ack0, 1'b0);
    end

    // Reset during the strobe of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 21'h0F000; wdata0 = 8'hE7;
    tick();
    req0 = 1'b0;
    tick();
    chk("pre_rst_nWE", nwe0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk_reset_state();
    @(negedge clk) reset = 1'b0;
    last_rd = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_ack", ack0, 1'b0);
      chk("post_rst_busy", busy0, 1'b0);
    end
    txn0(1'b0, 21'h00010, 8'h00, 1'b0, 1'b0);
    tick();

    // Randomized accesses over a small address window
    for (int i = 0; i < 40; i++) begin
      int gap;
      txn0(1'($urandom), 21'h1FFF0 | 21'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end

    // Slow-timing read on the second instance
    req1 = 1'b1; we1 = 1'b0; addr1 = 21'h00ABC;
    tick();
    req1 = 1'b0; addr1 = 21'h0;
    for (int k = 0; k <= 7; k++) begin
      chk("slow_nOE", noe1, (k >= 2 && k <= 5) ? 1'b0 : 1'b1);
      chk("slow_nCE", nce1, (k < 7) ? 1'b0 : 1'b1);
      chk("slow_nWE", nwe1, 1'b1);
      chk("slow_busy", busy1, k < 7);
      chk("slow_ack", ack1, k == 7);
      if (k >= 2 && k <= 5) chk("slow_dq", dq1, 8'h2A);
      if (k == 7) chk("slow_rdata", rdata1, 8'h2A);
      if (k < 7) tick();
    end
    tick();
    chk("slow_ack_once", ack1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
